// File: rtl/ro_heater_seq.sv
// Ring-oscillator heater sequencer: captures a heater command, then issues
// periodic single-cycle start pulses until the repeat count is met or aborted.
module ro_heater_seq #(
  parameter int DATA_W      = 256,
  parameter int LEN_W       = 9,
  parameter int MAX_HEATERS = 5,
  parameter int PERIOD_W    = 32,
  parameter int REPEAT_W    = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [DATA_W-1:0]   cmd_data,
  input  logic [LEN_W-1:0]    cmd_data_len,
  input  logic [7:0]          cmd_on_num,
  input  logic [PERIOD_W-1:0] cmd_period,
  input  logic [REPEAT_W-1:0] cmd_repeat,
  input  logic                abort,
  output logic                ro_heater_start,
  output logic [DATA_W-1:0]   ro_heater_data,
  output logic [LEN_W-1:0]    ro_heater_data_len,
  output logic [7:0]          ro_heater_on_num,
  output logic                busy,
  output logic                done,
  output logic [REPEAT_W-1:0] pulse_count
);

  typedef enum logic [1:0] {ST_IDLE, ST_PULSE, ST_WAIT, ST_DONE} state_t;

  state_t              state_reg, state_next;
  logic                live_reg;
  logic [DATA_W-1:0]   data_reg;
  logic [LEN_W-1:0]    len_reg;
  logic [7:0]          on_num_reg;
  logic [PERIOD_W-1:0] period_reg;
  logic [PERIOD_W-1:0] cnt_reg;
  logic [REPEAT_W-1:0] repeat_reg;
  logic [REPEAT_W-1:0] count_reg;

  logic                accept;
  logic [REPEAT_W-1:0] count_inc;
  logic                last_pulse;

  assign accept     = cmd_valid && cmd_ready;
  assign count_inc  = (&count_reg) ? count_reg : count_reg + REPEAT_W'(1);
  assign last_pulse = (repeat_reg != '0) && (count_inc == repeat_reg);

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:  if (accept) state_next = ST_PULSE;
      ST_PULSE: state_next = (abort || last_pulse) ? ST_DONE : ST_WAIT;
      ST_WAIT: begin
        if (abort) begin
          state_next = ST_DONE;
        end else if (cnt_reg == PERIOD_W'(1)) begin
          state_next = ST_PULSE;
        end
      end
      ST_DONE:  state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  // Outputs decoded from state; live_reg holds cmd_ready low until a
  // clock edge has passed with reset released.
  always_comb begin
    cmd_ready       = 1'b0;
    ro_heater_start = 1'b0;
    busy            = 1'b0;
    done            = 1'b0;
    case (state_reg)
      ST_IDLE:  cmd_ready = live_reg;
      ST_PULSE: begin
        ro_heater_start = 1'b1;
        busy            = 1'b1;
      end
      ST_WAIT:  busy = 1'b1;
      ST_DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: ;
    endcase
  end

  // Command capture, period counter and pulse counter
  always_ff @(posedge clk) begin
    if (rst) begin
      live_reg   <= 1'b0;
      data_reg   <= '0;
      len_reg    <= '0;
      on_num_reg <= '0;
      period_reg <= '0;
      repeat_reg <= '0;
      cnt_reg    <= '0;
      count_reg  <= '0;
    end else begin
      live_reg <= 1'b1;
      if (accept) begin
        data_reg   <= cmd_data;
        len_reg    <= (int'(cmd_data_len) > DATA_W) ? LEN_W'(DATA_W) : cmd_data_len;
        on_num_reg <= (int'(cmd_on_num) > MAX_HEATERS) ? 8'(MAX_HEATERS) : cmd_on_num;
        period_reg <= (cmd_period < PERIOD_W'(2)) ? PERIOD_W'(2) : cmd_period;
        repeat_reg <= cmd_repeat;
        count_reg  <= '0;
      end
      if (state_reg == ST_PULSE) begin
        count_reg <= count_inc;
        cnt_reg   <= period_reg - PERIOD_W'(1);
      end else if (state_reg == ST_WAIT) begin
        cnt_reg <= cnt_reg - PERIOD_W'(1);
      end
    end
  end

  assign ro_heater_data     = data_reg;
  assign ro_heater_data_len = len_reg;
  assign ro_heater_on_num   = on_num_reg;
  assign pulse_count        = count_reg;

endmodule
